// File: rtl/rev_reg_slice_pkg.sv
// Shared types and constants for the rev_reg_slice two-entry register slice.
package rev_reg_slice_pkg;

    // Slice fill state. Encoding 2'd3 is illegal and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    // Occupancy values reported on the occupancy port.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Map a state to the number of beats it holds; illegal encodings report empty.
    function automatic logic [1:0] state_occupancy(input slice_state_e state);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (state)
            EMPTY:   occ = OCC_EMPTY;
            ONE:     occ = OCC_ONE;
            FULL:    occ = OCC_FULL;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

    // True when the state presents a beat to the consumer.
    function automatic logic state_has_beat(input slice_state_e state);
        return (state == ONE) || (state == FULL);
    endfunction

endpackage

// File: rtl/rev_reg_slice.sv
// Two-entry valid/ready register slice. Every output comes straight from a
// flop (or a decode of the state flop), so no input-to-output combinational
// path exists in either direction. The main register drives out_data; the
// skid register catches the single beat in flight when the consumer stalls.
module rev_reg_slice
    import rev_reg_slice_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    slice_state_e     state_q;
    slice_state_e     state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             in_ready_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_from_in;
    logic             load_main_from_skid;
    logic             load_skid;

    // Handshake decode from registered outputs only.
    assign out_valid = state_has_beat(state_q);
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;

    // Next-state and data-steering decode for the three-state fill FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path leaves it unassigned and infers a latch.
        state_d             = state_q;
        load_main_from_in   = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid           = 1'b0;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_from_in = 1'b1;
                    state_d           = ONE;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b11: begin
                        // Beat leaves and the next one replaces it directly.
                        load_main_from_in = 1'b1;
                        state_d           = ONE;
                    end
                    2'b01: begin
                        state_d = EMPTY;
                    end
                    2'b10: begin
                        // Consumer stalled with a beat in flight: park it in skid.
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end
                    default: begin
                        state_d = ONE;
                    end
                endcase
            end
            FULL: begin
                // in_ready is low here, so only the output side can move.
                if (out_xfer) begin
                    load_main_from_skid = 1'b1;
                    state_d             = ONE;
                end
            end
            default: begin
                // Illegal encoding: recover to a clean empty slice.
                state_d = EMPTY;
            end
        endcase

        // Accept unless the slice will be full after this edge.
        in_ready_d = (state_d != FULL);
    end

    // State register and registered ready; reset discards any held beats.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Main (output) data register: loads from the producer or from skid.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset because the interface promises out_data=0 after reset, not just a cleared valid.
        if (rst) begin
            main_q <= '0;
        end else if (load_main_from_in) begin
            main_q <= in_data;
        end else if (load_main_from_skid) begin
            main_q <= skid_q;
        end
    end

    // Skid register: captures the beat accepted while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_rev_reg_slice.sv
// Self-checking bench for rev_reg_slice: directed vector table, a streaming
// sequence, random backpressure against a queue scoreboard, and a drain.
module tb_rev_reg_slice;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       occupancy;

    int errors;
    int checks;

    rev_reg_slice #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs held across one rising edge, outputs expected after it.
    typedef struct {
        string      name;
        logic       rst;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic       chk_data;
        logic [7:0] exp_out_data;
        logic [1:0] exp_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic iv, logic [7:0] d, logic ordy,
                                logic eir, logic eov, logic cd, logic [7:0] ed, logic [1:0] eocc);
        vec_t v;
        v.name = name; v.rst = r; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
        v.exp_in_ready = eir; v.exp_out_valid = eov; v.chk_data = cd;
        v.exp_out_data = ed; v.exp_occ = eocc;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic iv, logic [7:0] d, logic ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Drive inputs, cross one rising edge, sample 1 time unit later.
    task automatic step(logic r, logic iv, logic [7:0] d, logic ordy);
        drive(r, iv, d, ordy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] sb[$];
        logic [7:0] got;
        int         sent;
        int         recvd;
        int         budget;
        logic       pre_in_ready;
        logic       pre_out_valid;
        logic [7:0] pre_out_data;
        logic       iv;
        logic       ordy;

        errors = 0;
        checks = 0;
        drive(1'b1, 1'b1, 8'hA5, 1'b1);

        // name, rst, in_valid, in_data, out_ready, exp_in_ready, exp_out_valid, chk_data, exp_data, exp_occ
        vecs.push_back(mk("rst_hold0",   1, 1, 8'hA5, 1, 0, 0, 1, 8'h00, 0));
        vecs.push_back(mk("rst_hold1",   1, 1, 8'hA5, 1, 0, 0, 1, 8'h00, 0));
        vecs.push_back(mk("rst_hold2",   1, 1, 8'hA5, 1, 0, 0, 1, 8'h00, 0));
        vecs.push_back(mk("first_rdy",   0, 1, 8'hA5, 0, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk("a5_out",      0, 1, 8'hA5, 0, 1, 1, 1, 8'hA5, 1));
        vecs.push_back(mk("a5_taken",    0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk("skid_20",     0, 1, 8'h20, 1, 1, 1, 1, 8'h20, 1));
        vecs.push_back(mk("skid_21",     0, 1, 8'h21, 1, 1, 1, 1, 8'h21, 1));
        vecs.push_back(mk("skid_catch",  0, 1, 8'h22, 0, 0, 1, 1, 8'h21, 2));
        vecs.push_back(mk("skid_hold",   0, 1, 8'h23, 0, 0, 1, 1, 8'h21, 2));
        vecs.push_back(mk("skid_rel",    0, 0, 8'h00, 1, 1, 1, 1, 8'h22, 1));
        vecs.push_back(mk("skid_empty",  0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk("rf_one",      0, 1, 8'h30, 0, 1, 1, 1, 8'h30, 1));
        vecs.push_back(mk("rf_full",     0, 1, 8'h31, 0, 0, 1, 1, 8'h30, 2));
        vecs.push_back(mk("rf_rst",      1, 1, 8'h32, 1, 0, 0, 1, 8'h00, 0));
        vecs.push_back(mk("rf_after0",   0, 0, 8'h00, 1, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk("rf_after1",   0, 0, 8'h00, 1, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk("drain_one",   0, 1, 8'h40, 0, 1, 1, 1, 8'h40, 1));
        vecs.push_back(mk("drain_full",  0, 1, 8'h41, 0, 0, 1, 1, 8'h40, 2));
        vecs.push_back(mk("drain_b1",    0, 0, 8'h00, 1, 1, 1, 1, 8'h41, 1));
        vecs.push_back(mk("drain_b2",    0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            check({vecs[i].name, ".in_ready"},  {31'd0, in_ready},  {31'd0, vecs[i].exp_in_ready});
            check({vecs[i].name, ".out_valid"}, {31'd0, out_valid}, {31'd0, vecs[i].exp_out_valid});
            check({vecs[i].name, ".occupancy"}, {30'd0, occupancy}, {30'd0, vecs[i].exp_occ});
            if (vecs[i].chk_data)
                check({vecs[i].name, ".out_data"}, {24'd0, out_data}, {24'd0, vecs[i].exp_out_data});
        end

        // Streaming: 01..10 back-to-back with the consumer always ready.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b1);
            check("stream.out_valid", {31'd0, out_valid}, 32'd1);
            check("stream.out_data",  {24'd0, out_data},  i);
            check("stream.occupancy", {30'd0, occupancy}, 32'd1);
            check("stream.in_ready",  {31'd0, in_ready},  32'd1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("stream_end.out_valid", {31'd0, out_valid}, 32'd0);
        check("stream_end.occupancy", {30'd0, occupancy}, 32'd0);

        // Random backpressure against a queue scoreboard.
        sent   = 0;
        recvd  = 0;
        budget = 0;
        while (sent < 1000 && budget < 20000) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            pre_in_ready  = in_ready;
            pre_out_valid = out_valid;
            pre_out_data  = out_data;
            step(1'b0, iv, 8'(sent), ordy);
            budget++;
            if (pre_out_valid && ordy) begin
                if (sb.size() == 0) begin
                    check("rand.spurious_beat", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("rand.order", {24'd0, pre_out_data}, {24'd0, got});
                    recvd++;
                end
            end
            if (iv && pre_in_ready) begin
                sb.push_back(8'(sent));
                sent++;
            end
            check("rand.occupancy", {30'd0, occupancy}, sb.size());
        end
        if (budget >= 20000)
            check("rand.budget_expired", 32'd1, 32'd0);

        // Drain whatever the scoreboard still expects.
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            pre_out_valid = out_valid;
            pre_out_data  = out_data;
            step(1'b0, 1'b0, 8'h00, 1'b1);
            budget++;
            if (pre_out_valid) begin
                got = sb.pop_front();
                check("rand_drain.order", {24'd0, pre_out_data}, {24'd0, got});
                recvd++;
            end
        end
        check("rand.delivered", recvd, 32'd1000);
        check("rand.final_valid", {31'd0, out_valid}, 32'd0);
        check("rand.final_occ",   {30'd0, occupancy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
